addsub_cla_pipe: RTL and testbench

//  Pipelined, parametrised two's-complement adder/subtractor. W-bit operands split into

---
 rtl/addsub_pkg.sv | 9 +
 rtl/cla_slice.sv | 34 +++
 rtl/addsub_cla_pipe.sv | 125 ++++++++++++
 tb/tb_addsub_cla_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
package addsub_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/cla_slice.sv
// One BLK-bit carry-lookahead slice of the adder/subtractor; purely combinational.
module cla_slice #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           m,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout,
    output logic           c_msb_in
);

    logic [BLK-1:0] bx;
    logic [BLK-1:0] p;
    logic [BLK-1:0] g;
    logic [BLK:0]   c;

    always_comb begin
        bx   = b ^ {BLK{m}};
        p    = a ^ bx;
        g    = a & bx;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < BLK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign s        = p ^ c[BLK-1:0];
    assign cout     = c[BLK];
    assign c_msb_in = c[BLK-1];

endmodule

// File: rtl/addsub_cla_pipe.sv
// Pipelined two's-complement adder/subtractor: one CLA slice per stage, carry
// registered between stages, valid/ready handshake, NZCV flags from the last stage.
module addsub_cla_pipe
    import addsub_pkg::*;
#(
    parameter int W   = 16,
    parameter int BLK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_m,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_s,
    output logic         out_c,
    output logic         out_v,
    output logic         out_n,
    output logic         out_z
);

    localparam int unsigned NSEG = W / BLK;

    if ((W % BLK) != 0 || W < BLK) begin : g_bad_cfg
        $error("addsub_cla_pipe: W must be a non-zero multiple of BLK");
    end

    logic           adv;

    logic           st_vld [NSEG];
    logic           st_m   [NSEG];
    logic           st_c   [NSEG];
    logic           st_cm  [NSEG];
    logic           st_z   [NSEG];
    logic [W-1:0]   st_s   [NSEG];
    logic [W-1:0]   st_a   [NSEG];
    logic [W-1:0]   st_b   [NSEG];

    logic [BLK-1:0] sl_a   [NSEG];
    logic [BLK-1:0] sl_b   [NSEG];
    logic           sl_m   [NSEG];
    logic           sl_ci  [NSEG];
    logic [BLK-1:0] sl_s   [NSEG];
    logic           sl_co  [NSEG];
    logic           sl_cm  [NSEG];
    logic [W-1:0]   s_nxt  [NSEG];
    logic           z_nxt  [NSEG];

    // Whole pipe moves together; a stalled output freezes every stage.
    assign adv      = !st_vld[NSEG-1] | out_ready;
    assign in_ready = adv;

    always_comb begin
        sl_a[0]  = in_a[BLK-1:0];
        sl_b[0]  = in_b[BLK-1:0];
        sl_m[0]  = (in_m == MODE_SUB);
        sl_ci[0] = (in_m == MODE_SUB);
        s_nxt[0] = W'(sl_s[0]);
        z_nxt[0] = ~|sl_s[0];
        for (int unsigned k = 1; k < NSEG; k++) begin
            sl_a[k]  = st_a[k-1][k*BLK +: BLK];
            sl_b[k]  = st_b[k-1][k*BLK +: BLK];
            sl_m[k]  = st_m[k-1];
            sl_ci[k] = st_c[k-1];
            s_nxt[k] = st_s[k-1];
            s_nxt[k][k*BLK +: BLK] = sl_s[k];
            z_nxt[k] = st_z[k-1] & ~|sl_s[k];
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_slice
        cla_slice #(.BLK(BLK)) u_slice (
            .a        (sl_a[k]),
            .b        (sl_b[k]),
            .m        (sl_m[k]),
            .cin      (sl_ci[k]),
            .s        (sl_s[k]),
            .cout     (sl_co[k]),
            .c_msb_in (sl_cm[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NSEG; k++) begin
                st_vld[k] <= 1'b0;
                st_m[k]   <= 1'b0;
                st_c[k]   <= 1'b0;
                st_cm[k]  <= 1'b0;
                st_z[k]   <= 1'b0;
                st_s[k]   <= '0;
                st_a[k]   <= '0;
                st_b[k]   <= '0;
            end
        end else if (adv) begin
            st_vld[0] <= in_valid;
            st_m[0]   <= in_m;
            st_a[0]   <= in_a;
            st_b[0]   <= in_b;
            for (int unsigned k = 1; k < NSEG; k++) begin
                st_vld[k] <= st_vld[k-1];
                st_m[k]   <= st_m[k-1];
                st_a[k]   <= st_a[k-1];
                st_b[k]   <= st_b[k-1];
            end
            for (int unsigned k = 0; k < NSEG; k++) begin
                st_s[k]  <= s_nxt[k];
                st_c[k]  <= sl_co[k];
                st_cm[k] <= sl_cm[k];
                st_z[k]  <= z_nxt[k];
            end
        end
    end

    assign out_valid = st_vld[NSEG-1];
    assign out_s     = st_s[NSEG-1];
    assign out_c     = st_c[NSEG-1];
    assign out_v     = st_c[NSEG-1] ^ st_cm[NSEG-1];
    assign out_n     = st_s[NSEG-1][W-1];
    assign out_z     = st_z[NSEG-1];

endmodule

// File: tb/tb_addsub_cla_pipe.sv
// Self-checking bench: directed table, stall/reset sequences on W=16/BLK=4,
// randomized traffic on W=8/BLK=8 and W=32/BLK=8 against an arithmetic model.
module tb_addsub_cla_pipe;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        v;
        logic        n;
        logic        z;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        res_t        exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        x_iv, x_ir, x_m, x_ov, x_or, x_c, x_v, x_n, x_z;
    logic [15:0] x_a, x_b, x_s;
    logic        p_iv, p_ir, p_m, p_ov, p_or, p_c, p_v, p_n, p_z;
    logic [7:0]  p_a, p_b, p_s;
    logic        q_iv, q_ir, q_m, q_ov, q_or, q_c, q_v, q_n, q_z;
    logic [31:0] q_a, q_b, q_s;

    addsub_cla_pipe #(.W(16), .BLK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(x_iv), .in_ready(x_ir), .in_a(x_a), .in_b(x_b),
        .in_m(x_m), .out_valid(x_ov), .out_ready(x_or), .out_s(x_s), .out_c(x_c),
        .out_v(x_v), .out_n(x_n), .out_z(x_z));

    addsub_cla_pipe #(.W(8), .BLK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(p_iv), .in_ready(p_ir), .in_a(p_a), .in_b(p_b),
        .in_m(p_m), .out_valid(p_ov), .out_ready(p_or), .out_s(p_s), .out_c(p_c),
        .out_v(p_v), .out_n(p_n), .out_z(p_z));

    addsub_cla_pipe #(.W(32), .BLK(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(q_iv), .in_ready(q_ir), .in_a(q_a), .in_b(q_b),
        .in_m(q_m), .out_valid(q_ov), .out_ready(q_or), .out_s(q_s), .out_c(q_c),
        .out_v(q_v), .out_n(q_n), .out_z(q_z));

    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc   = 0;
    res_t  mq[$];
    int    aq[$];
    res_t  next_exp;
    logic  check_lat;
    logic  stalled;
    logic  took;
    string tag;
    vec_t  vecs[10];

    // Reference: exact integer arithmetic, then reduce modulo 2^w.
    function automatic res_t model(int w, logic [31:0] a, logic [31:0] b, logic m);
        longint lim, ua, ub, sa, sb, sum, ex;
        res_t   r;
        lim  = longint'(1) << w;
        ua   = longint'(a) & (lim - 1);
        ub   = longint'(b) & (lim - 1);
        sa   = (ua >= lim / 2) ? ua - lim : ua;
        sb   = (ub >= lim / 2) ? ub - lim : ub;
        sum  = m ? ua - ub : ua + ub;
        ex   = m ? sa - sb : sa + sb;
        r.s  = 32'(((sum % lim) + lim) % lim);
        r.c  = m ? (ua >= ub) : (sum >= lim);
        r.v  = (ex < -(lim / 2)) || (ex >= lim / 2);
        r.n  = longint'(r.s) >= lim / 2;
        r.z  = (r.s == 32'h0);
        return r;
    endfunction

    function automatic vec_t mk(logic [15:0] a, logic [15:0] b, logic m, logic [15:0] s,
                                logic c, logic v, logic n, logic z);
        vec_t t;
        t.a = a; t.b = b; t.m = m;
        t.exp = {16'h0, s, c, v, n, z};
        return t;
    endfunction

    // Called at posedge+1; evaluates the handshake of the current cycle, then advances.
    task automatic step_main();
        res_t got, exp;
        int   lat;
        #1;
        took    = x_iv && x_ir;
        stalled = x_ov && !x_or;
        if (took) begin
            mq.push_back(next_exp);
            aq.push_back(cyc);
        end
        if (x_ov) begin
            got = {16'h0, x_s, x_c, x_v, x_n, x_z};
            n_vec++;
            if (mq.size() == 0) begin
                n_bad++;
                $display("FAIL %s: unexpected result s=%h with nothing outstanding", tag, x_s);
            end else begin
                exp = mq[0];
                lat = cyc - aq[0];
                if (got !== exp || (x_or && check_lat && lat != 4) || (!x_or && x_ir !== 1'b0)) begin
                    n_bad++;
                    $display("FAIL %s: got s=%h cvnz=%b%b%b%b lat=%0d in_ready=%b, want s=%h cvnz=%b%b%b%b lat=4 in_ready=%b",
                             tag, got.s, got.c, got.v, got.n, got.z, lat, x_ir,
                             exp.s, exp.c, exp.v, exp.n, exp.z, x_or);
                end
                if (x_or) begin
                    void'(mq.pop_front());
                    void'(aq.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain_main();
        x_iv = 1'b0;
        x_or = 1'b1;
        for (int t = 0; t < 50 && mq.size() > 0; t++) step_main();
        if (mq.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: timeout, %0d results still outstanding, want 0", tag, mq.size());
            mq.delete();
            aq.delete();
        end
    endtask

    task automatic check_reset(string name);
        n_vec++;
        if (x_ov !== 1'b0 || x_s !== 16'h0 || {x_c, x_v, x_n, x_z} !== 4'b0 || x_ir !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: got valid=%b s=%h cvnz=%b%b%b%b in_ready=%b, want 0 0000 0000 1",
                     name, x_ov, x_s, x_c, x_v, x_n, x_z, x_ir);
        end
    endtask

    task automatic run_rand(int d, int nops, bit rnd_ready);
        int          w, lat, sent, l;
        res_t        got, exp;
        res_t        rq[$];
        int          raq[$];
        logic [31:0] ra, rb;
        logic        rm, riv, rir, rov, ror, pend;
        w = (d == 0) ? 8 : 32;
        lat = (d == 0) ? 1 : 4;
        sent = 0;
        riv = 1'b0; pend = 1'b0; ra = '0; rb = '0; rm = 1'b0;
        tag = $sformatf("rand_w%0d_%s", w, rnd_ready ? "stall" : "flow");
        for (int t = 0; t < nops * 8 + 100 && (sent < nops || rq.size() > 0); t++) begin
            if (sent >= nops) riv = 1'b0;
            else if (!pend) begin
                riv = ($urandom_range(0, 3) != 0);
                ra  = $urandom;
                rb  = $urandom;
                rm  = 1'($urandom_range(0, 1));
            end
            ror = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (d == 0) begin
                p_iv = riv; p_a = ra[7:0]; p_b = rb[7:0]; p_m = rm; p_or = ror;
            end else begin
                q_iv = riv; q_a = ra; q_b = rb; q_m = rm; q_or = ror;
            end
            #1;
            rir = (d == 0) ? p_ir : q_ir;
            rov = (d == 0) ? p_ov : q_ov;
            got = (d == 0) ? {24'h0, p_s, p_c, p_v, p_n, p_z} : {q_s, q_c, q_v, q_n, q_z};
            pend = riv && !rir;
            if (riv && rir) begin
                rq.push_back(model(w, ra, rb, rm));
                raq.push_back(cyc);
                sent++;
            end
            if (rov && ror) begin
                n_vec++;
                if (rq.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s: unexpected result s=%h with nothing outstanding", tag, got.s);
                end else begin
                    exp = rq.pop_front();
                    l   = cyc - raq.pop_front();
                    if (got !== exp || (!rnd_ready && l != lat)) begin
                        n_bad++;
                        $display("FAIL %s: got s=%h cvnz=%b%b%b%b lat=%0d, want s=%h cvnz=%b%b%b%b lat=%0d",
                                 tag, got.s, got.c, got.v, got.n, got.z, l,
                                 exp.s, exp.c, exp.v, exp.n, exp.z, lat);
                    end
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        p_iv = 1'b0; q_iv = 1'b0; p_or = 1'b1; q_or = 1'b1;
        if (sent < nops || rq.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: timeout, sent %0d of %0d, %0d outstanding", tag, sent, nops, rq.size());
        end
    endtask

    initial begin
        int sent, held;

        vecs[0] = mk(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[1] = mk(16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[2] = mk(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[3] = mk(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[4] = mk(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[5] = mk(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[6] = mk(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
        vecs[7] = mk(16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[8] = mk(16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[9] = mk(16'h0003, 16'h0007, 1'b1, 16'hFFFC, 1'b0, 1'b0, 1'b1, 1'b0);

        rst_n = 1'b0;
        x_iv = 1'b0; x_a = '0; x_b = '0; x_m = 1'b0; x_or = 1'b1;
        p_iv = 1'b0; p_a = '0; p_b = '0; p_m = 1'b0; p_or = 1'b1;
        q_iv = 1'b0; q_a = '0; q_b = '0; q_m = 1'b0; q_or = 1'b1;
        check_lat = 1'b1;
        next_exp = '0;
        tag = "init";
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_state");
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            tag = $sformatf("vec%0d", i);
            x_a = vecs[i].a; x_b = vecs[i].b; x_m = vecs[i].m;
            next_exp = vecs[i].exp;
            x_iv = 1'b1;
            step_main();
            drain_main();
        end

        tag = "back_to_back";
        for (int i = 0; i < 8; i++) begin
            x_a = 16'($urandom); x_b = 16'($urandom); x_m = 1'($urandom_range(0, 1));
            next_exp = model(16, {16'h0, x_a}, {16'h0, x_b}, x_m);
            x_iv = 1'b1;
            step_main();
        end
        drain_main();

        // Fill the pipe with the consumer stalled, hold three cycles, then release.
        tag = "stall";
        check_lat = 1'b0;
        sent = 0;
        held = 0;
        for (int t = 0; t < 60 && (sent < 6 || mq.size() > 0); t++) begin
            x_or = (held >= 3);
            if (sent < 6) begin
                x_a = 16'(16'h1111 * (sent + 1));
                x_b = 16'(16'h0F0F + sent);
                x_m = 1'(sent % 2);
                next_exp = model(16, {16'h0, x_a}, {16'h0, x_b}, x_m);
                x_iv = 1'b1;
            end else x_iv = 1'b0;
            step_main();
            if (took) sent++;
            if (stalled) begin
                held++;
                if (held == 3) begin
                    n_vec++;
                    if (sent != 4) begin
                        n_bad++;
                        $display("FAIL stall_fill: accepted %0d before stall, want 4", sent);
                    end
                end
            end
        end
        if (sent < 6 || mq.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL stall: timeout, sent %0d of 6, %0d outstanding", sent, mq.size());
        end
        check_lat = 1'b1;
        drain_main();

        tag = "reset_mid";
        for (int i = 0; i < 3; i++) begin
            x_a = 16'($urandom); x_b = 16'($urandom); x_m = 1'b0;
            next_exp = model(16, {16'h0, x_a}, {16'h0, x_b}, x_m);
            x_iv = 1'b1;
            step_main();
        end
        x_iv = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset("reset_mid");
        mq.delete();
        aq.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset_hold");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        tag = "post_reset";
        x_a = 16'h0102; x_b = 16'h0304; x_m = 1'b0;
        next_exp = model(16, 32'h0102, 32'h0304, 1'b0);
        x_iv = 1'b1;
        step_main();
        drain_main();

        run_rand(0, 500, 1'b0);
        run_rand(0, 500, 1'b1);
        run_rand(1, 500, 1'b0);
        run_rand(1, 500, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
